// File: rtl/tx_arbiter_rr_pkg.sv
// Shared types and defaults for the round-robin transmit arbiter.
// Defining TX_ARB_HEADER_EN adds the HEADER state and the header magic nibble.
`ifndef TX_ARB_DEF_DATA_WIDTH
`define TX_ARB_DEF_DATA_WIDTH 8
`endif
`ifndef TX_ARB_DEF_SOURCES
`define TX_ARB_DEF_SOURCES 3
`endif

package tx_arbiter_rr_pkg;

`ifdef TX_ARB_HEADER_EN
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRAME  = 2'd1,
    ST_HEADER = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1
  } arb_state_e;
`endif

endpackage

// File: rtl/tx_arbiter_rr_if.sv
// Framed simple-interface bundle between the producers, the arbiter and the FT245 tx side.
interface tx_arbiter_rr_if #(
  parameter int DATA_WIDTH = `TX_ARB_DEF_DATA_WIDTH,
  parameter int SOURCES    = `TX_ARB_DEF_SOURCES,
  parameter int ID_WIDTH   = 4
);
  logic [SOURCES*DATA_WIDTH-1:0] src_data;
  logic [SOURCES-1:0]            src_rdy;
  logic [SOURCES-1:0]            src_eof;
  logic [SOURCES-1:0]            src_ack;
  logic [SOURCES-1:0]            src_en;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_rdy;
  logic                          tx_ack;
  logic                          busy;
  logic [ID_WIDTH-1:0]           grant_id;

  modport master (
    output src_data, src_rdy, src_eof, src_en, tx_ack,
    input  src_ack, tx_data, tx_rdy, busy, grant_id
  );

  modport slave (
    input  src_data, src_rdy, src_eof, src_en, tx_ack,
    output src_ack, tx_data, tx_rdy, busy, grant_id
  );
endinterface

// File: rtl/tx_arbiter_rr_rr_pick.sv
// Combinational rotating priority encoder: first set bit of req at or above rr_ptr, wrapping.
module rr_pick
  import tx_arbiter_rr_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sum;

  // Rotating the doubled vector puts the rr_ptr position at bit 0, so a plain scan suffices.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    dbl   = {req, req} >> rr_ptr;
    rot   = dbl[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr) + i;
        if (sum >= N) begin
          sum = sum - N;
        end
        idx = IW'(sum);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter_rr.sv
// Round-robin, frame-locked merge of SOURCES framed producers onto one tx consumer.
// Optional TX_ARB_HEADER_EN prefixes every frame with {4'hA, grant_id}.
module tx_arbiter_rr
  import tx_arbiter_rr_pkg::*;
#(
  parameter int DATA_WIDTH = `TX_ARB_DEF_DATA_WIDTH,
  parameter int SOURCES    = `TX_ARB_DEF_SOURCES,
  parameter int ID_WIDTH   = 4
) (
  input logic            clk,
  input logic            rst,
  tx_arbiter_rr_if.slave bus
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic                  busy_q, busy_d;

  logic [SOURCES-1:0]    req;
  logic                  found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [ID_WIDTH-1:0]   next_ptr;

  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_rdy;
  logic                  gnt_eof;
  logic                  frame_accept;

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_rdy;
  logic [SOURCES-1:0]    src_ack;

  assign req = bus.src_rdy & bus.src_en;

  rr_pick #(
    .N  (SOURCES),
    .IW (ID_WIDTH)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .idx    (pick_idx)
  );

  always_comb begin
    gnt_data = '0;
    gnt_rdy  = 1'b0;
    gnt_eof  = 1'b0;
    for (int i = 0; i < SOURCES; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        gnt_data = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_rdy  = bus.src_rdy[i];
        gnt_eof  = bus.src_eof[i];
      end
    end
  end

  assign frame_accept = (state_q == ST_FRAME) && gnt_rdy && bus.tx_ack;
  assign next_ptr     = (grant_id_q >= ID_WIDTH'(SOURCES - 1)) ? '0 : grant_id_q + 1'b1;

`ifdef TX_ARB_HEADER_EN
  logic [DATA_WIDTH-5:0] hdr_id;
  assign hdr_id = (DATA_WIDTH-4)'(grant_id_q);
`endif

  // Link outputs are a pass-through of the locked source; nothing leaves the block while idle.
  always_comb begin
    tx_data = '0;
    tx_rdy  = 1'b0;
    src_ack = '0;
    case (state_q)
      ST_FRAME: begin
        tx_data = gnt_data;
        tx_rdy  = gnt_rdy;
        for (int i = 0; i < SOURCES; i++) begin
          src_ack[i] = frame_accept && (grant_id_q == ID_WIDTH'(i));
        end
      end
`ifdef TX_ARB_HEADER_EN
      ST_HEADER: begin
        tx_data = {HDR_MAGIC, hdr_id};
        tx_rdy  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_id_d = pick_idx;
          busy_d     = 1'b1;
`ifdef TX_ARB_HEADER_EN
          state_d    = ST_HEADER;
`else
          state_d    = ST_FRAME;
`endif
        end
      end
`ifdef TX_ARB_HEADER_EN
      ST_HEADER: begin
        if (bus.tx_ack) begin
          state_d = ST_FRAME;
        end
      end
`endif
      ST_FRAME: begin
        // Only the acknowledged eof word releases the lock and advances the rotation.
        if (frame_accept && gnt_eof) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.tx_data  = tx_data;
  assign bus.tx_rdy   = tx_rdy;
  assign bus.src_ack  = src_ack;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule
